// File: rtl/window_scan_sequencer.sv
// Sequences a multi-scale sliding-window scan: requests each scale's geometry, starts
// its image prep, then issues CORES-wide window batches and emits one record per batch.
module window_scan_sequencer #(
   parameter int CORES = 4,
   parameter int CW    = 10,
   parameter int SW    = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CW-1:0]    cfg_width_i,
   input  logic [CW-1:0]    cfg_height_i,
   input  logic [SW-1:0]    cfg_num_scales_i,
   output logic             ready_o,
   output logic             done_o,
   output logic             scale_req_o,
   input  logic             scale_ack_i,
   output logic [SW-1:0]    scale_idx_o,
   input  logic [CW-1:0]    scale_w_i,
   input  logic [CW-1:0]    scale_h_i,
   input  logic [CW-1:0]    scale_win_i,
   output logic             prep_start_o,
   input  logic             prep_done_i,
   output logic             win_valid_o,
   input  logic             win_ready_i,
   output logic [CW-1:0]    win_x_o,
   output logic [CW-1:0]    win_y_o,
   output logic [CORES-1:0] win_mask_o,
   output logic             win_dblbuf_o,
   input  logic             proc_done_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [CW-1:0]    res_x_o,
   output logic [CW-1:0]    res_y_o,
   output logic [SW-1:0]    res_scale_o,
   output logic [CORES-1:0] res_mask_o,
   output logic             res_exit_o,
   output logic [15:0]      batch_cnt_o
);

   localparam int XW = CW + 2;

   typedef enum logic [3:0] {
      IDLE, SCALE_REQ, PREP, ISSUE, WAIT_PROC, STORE, ADVANCE, EXIT, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic [CW-1:0] scW_q, scW_d, scH_q, scH_d, scWin_q, scWin_d;
   logic [SW-1:0] scaleIdx_q, scaleIdx_d;
   logic [15:0]   batchCnt_q, batchCnt_d;
   logic          dblbuf_q, dblbuf_d;
   logic          skip_q, skip_d;
   logic          prepSent_q, prepSent_d;

   logic [XW-1:0]    xExt, yExt, wExt, hExt, winExt;
   logic [CORES-1:0] mask;
   logic             fitX, fitY, skipCond, lastScale;

   // Geometry arithmetic is widened by two bits so window-past-edge sums never wrap.
   assign xExt      = XW'(x_q);
   assign yExt      = XW'(y_q);
   assign wExt      = XW'(scW_q);
   assign hExt      = XW'(scH_q);
   assign winExt    = XW'(scWin_q);
   assign fitX      = (xExt + XW'(CORES) + winExt) <= wExt;
   assign fitY      = (yExt + XW'(1) + winExt) <= hExt;
   assign skipCond  = (scale_win_i > scale_w_i) || (scale_win_i > scale_h_i);
   assign lastScale = ((SW+1)'(scaleIdx_q) + (SW+1)'(1)) == (SW+1)'(cfg_num_scales_i);

   // Lane l is usable only if its whole window still fits inside the scaled width.
   always_comb begin
      mask = '0;
      for (int l = 0; l < CORES; l++) begin
         mask[l] = (xExt + XW'(l) + winExt) <= wExt;
      end
   end

   // State and datapath registers; reset abandons the frame outright.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         scW_q      <= '0;
         scH_q      <= '0;
         scWin_q    <= '0;
         scaleIdx_q <= '0;
         batchCnt_q <= '0;
         dblbuf_q   <= 1'b0;
         skip_q     <= 1'b0;
         prepSent_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         scW_q      <= scW_d;
         scH_q      <= scH_d;
         scWin_q    <= scWin_d;
         scaleIdx_q <= scaleIdx_d;
         batchCnt_q <= batchCnt_d;
         dblbuf_q   <= dblbuf_d;
         skip_q     <= skip_d;
         prepSent_q <= prepSent_d;
      end
   end

   // Next-state logic; abort overrides every transition and any pending handshake.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      scW_d      = scW_q;
      scH_d      = scH_q;
      scWin_d    = scWin_q;
      scaleIdx_d = scaleIdx_q;
      batchCnt_d = batchCnt_q;
      dblbuf_d   = dblbuf_q;
      skip_d     = skip_q;
      prepSent_d = prepSent_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               x_d        = '0;
               y_d        = '0;
               scaleIdx_d = '0;
               batchCnt_d = '0;
               dblbuf_d   = 1'b0;
               state_d    = (cfg_num_scales_i == '0) ? EXIT : SCALE_REQ;
            end
         end
         SCALE_REQ: begin
            if (scale_ack_i) begin
               scW_d      = scale_w_i;
               scH_d      = scale_h_i;
               scWin_d    = scale_win_i;
               skip_d     = skipCond;
               prepSent_d = 1'b0;
               state_d    = skipCond ? ADVANCE : PREP;
            end
         end
         PREP: begin
            prepSent_d = 1'b1;
            if (prep_done_i) begin
               x_d     = '0;
               y_d     = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (win_ready_i) begin
               if (batchCnt_q != 16'hFFFF) begin
                  batchCnt_d = batchCnt_q + 16'd1;
               end
               state_d = WAIT_PROC;
            end
         end
         WAIT_PROC: begin
            if (proc_done_i) begin
               state_d = STORE;
            end
         end
         STORE: begin
            if (res_ready_i) begin
               dblbuf_d = ~dblbuf_q;
               state_d  = ADVANCE;
            end
         end
         ADVANCE: begin
            if (!skip_q && fitX) begin
               x_d     = x_q + CW'(CORES);
               state_d = ISSUE;
            end else if (!skip_q && fitY) begin
               x_d     = '0;
               y_d     = y_q + CW'(1);
               state_d = ISSUE;
            end else begin
               scaleIdx_d = scaleIdx_q + SW'(1);
               state_d    = lastScale ? EXIT : SCALE_REQ;
            end
         end
         EXIT: begin
            if (res_ready_i) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (abort_i && !(state_q inside {IDLE, EXIT, DONE})) begin
         state_d    = EXIT;
         batchCnt_d = batchCnt_q;
         dblbuf_d   = dblbuf_q;
      end
   end

   assign ready_o      = (state_q == IDLE);
   assign done_o       = (state_q == DONE);
   assign scale_req_o  = (state_q == SCALE_REQ);
   assign scale_idx_o  = scaleIdx_q;
   assign prep_start_o = (state_q == PREP) && !prepSent_q;
   assign win_valid_o  = (state_q == ISSUE);
   assign win_x_o      = (state_q == ISSUE) ? x_q : '0;
   assign win_y_o      = (state_q == ISSUE) ? y_q : '0;
   assign win_mask_o   = (state_q == ISSUE) ? mask : '0;
   assign win_dblbuf_o = dblbuf_q;
   assign res_valid_o  = (state_q == STORE) || (state_q == EXIT);
   assign res_exit_o   = (state_q == EXIT);
   assign res_x_o      = (state_q == STORE) ? x_q : ((state_q == EXIT) ? cfg_width_i : '0);
   assign res_y_o      = (state_q == STORE) ? y_q : ((state_q == EXIT) ? cfg_height_i : '0);
   assign res_scale_o  = (state_q == STORE) ? scaleIdx_q : '0;
   assign res_mask_o   = (state_q == STORE) ? mask : '0;
   assign batch_cnt_o  = batchCnt_q;

endmodule

// File: tb/tb_window_scan_sequencer.sv
// Scoreboard bench for window_scan_sequencer: a modelled scan fills the expected queue and
// a negedge responder plays scale source, prep engine, cluster and result sink.
module tb_window_scan_sequencer;

   localparam int CORES = 4;
   localparam int CW    = 10;
   localparam int SW    = 5;

   typedef struct packed {
      logic             isExit;
      logic [CW-1:0]    x;
      logic [CW-1:0]    y;
      logic [SW-1:0]    scale;
      logic [CORES-1:0] mask;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [CW-1:0] cfgWidth = '0;
   logic [CW-1:0] cfgHeight = '0;
   logic [SW-1:0] cfgNumScales = '0;
   logic ready, done, scaleReq, prepStart, winValid, winDblbuf, resValid, resExit;
   logic [SW-1:0] scaleIdx, resScale;
   logic [CW-1:0] winX, winY, resX, resY;
   logic [CORES-1:0] winMask, resMask;
   logic [15:0] batchCnt;
   logic scaleAck = 1'b0;
   logic prepDone = 1'b0;
   logic winReady = 1'b0;
   logic procDone = 1'b0;
   logic resReady = 1'b0;
   logic [CW-1:0] scaleW = '0;
   logic [CW-1:0] scaleH = '0;
   logic [CW-1:0] scaleWin = '0;

   rec_t expQ[$];
   int   checks = 0;
   int   failures = 0;
   int   winStallCnt = 0;
   int   resStallCnt = 0;
   bit   forceWinReady = 1'b0;
   int   prepCnt = 0;
   int   procCnt = 0;
   int   prepStarts = 0;
   int   scaleAcks = 0;
   int   winAccepts = 0;
   logic expDbl = 1'b0;
   logic [CW-1:0] tabW[4];
   logic [CW-1:0] tabH[4];
   logic [CW-1:0] tabWin[4];
   rec_t curWin, curRes, winSnap, resSnap;
   logic winSnapDbl = 1'b0;
   logic winHeld = 1'b0;
   logic resHeld = 1'b0;

   window_scan_sequencer #(.CORES(CORES), .CW(CW), .SW(SW)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
      .cfg_width_i(cfgWidth), .cfg_height_i(cfgHeight), .cfg_num_scales_i(cfgNumScales),
      .ready_o(ready), .done_o(done),
      .scale_req_o(scaleReq), .scale_ack_i(scaleAck), .scale_idx_o(scaleIdx),
      .scale_w_i(scaleW), .scale_h_i(scaleH), .scale_win_i(scaleWin),
      .prep_start_o(prepStart), .prep_done_i(prepDone),
      .win_valid_o(winValid), .win_ready_i(winReady), .win_x_o(winX), .win_y_o(winY),
      .win_mask_o(winMask), .win_dblbuf_o(winDblbuf),
      .proc_done_i(procDone),
      .res_valid_o(resValid), .res_ready_i(resReady), .res_x_o(resX), .res_y_o(resY),
      .res_scale_o(resScale), .res_mask_o(resMask), .res_exit_o(resExit),
      .batch_cnt_o(batchCnt)
   );

   always #5 clk = ~clk;

   // Environment model: answers every DUT request on the falling edge, checks held
   // payloads for stability and compares each completed handshake with the queue head.
   always @(negedge clk) begin
      if (reset) begin
         scaleAck = 1'b0; prepDone = 1'b0; winReady = 1'b0; procDone = 1'b0; resReady = 1'b0;
         prepCnt = 0; procCnt = 0; winHeld = 1'b0; resHeld = 1'b0;
      end else begin
         scaleAck = scaleReq;
         if (scaleReq) begin
            scaleW   = tabW[scaleIdx[1:0]];
            scaleH   = tabH[scaleIdx[1:0]];
            scaleWin = tabWin[scaleIdx[1:0]];
            if (!abort) scaleAcks++;
         end
         prepDone = 1'b0;
         if (prepCnt != 0) begin
            prepCnt--;
            if (prepCnt == 0) prepDone = 1'b1;
         end
         if (prepStart) begin
            prepCnt = 2;
            prepStarts++;
         end
         procDone = 1'b0;
         if (procCnt != 0) begin
            procCnt--;
            if (procCnt == 0) procDone = 1'b1;
         end
         winReady = 1'b0;
         if (winValid) begin
            curWin = {1'b0, winX, winY, scaleIdx, winMask};
            if (winHeld) begin
               checks++;
               if ({curWin, winDblbuf} !== {winSnap, winSnapDbl}) begin
                  failures++;
                  $display("[TB] FAIL win_stable actual=%h required=%h", {curWin, winDblbuf}, {winSnap, winSnapDbl});
               end
            end
            winSnap = curWin;
            winSnapDbl = winDblbuf;
            if (winStallCnt > 0 && !forceWinReady) begin
               winStallCnt--;
               winHeld = 1'b1;
            end else begin
               winReady = 1'b1;
               winHeld = 1'b0;
               if (!abort) begin
                  winAccepts++;
                  procCnt = 3;
                  checks++;
                  if (expQ.size() == 0) begin
                     failures++;
                     $display("[TB] FAIL win_issue actual=%h required=none", curWin);
                  end else if ({curWin, winDblbuf} !== {expQ[0], expDbl}) begin
                     failures++;
                     $display("[TB] FAIL win_issue actual=%h required=%h", {curWin, winDblbuf}, {expQ[0], expDbl});
                  end
               end
            end
         end else begin
            if (winHeld && !abort) begin
               checks++;
               failures++;
               $display("[TB] FAIL win_valid_drop actual=0 required=1");
            end
            winHeld = 1'b0;
         end
         resReady = 1'b0;
         if (resValid) begin
            curRes = {resExit, resX, resY, resScale, resMask};
            if (resHeld) begin
               checks++;
               if (curRes !== resSnap) begin
                  failures++;
                  $display("[TB] FAIL res_stable actual=%h required=%h", curRes, resSnap);
               end
            end
            resSnap = curRes;
            if (resStallCnt > 0) begin
               resStallCnt--;
               resHeld = 1'b1;
            end else begin
               resReady = 1'b1;
               resHeld = 1'b0;
               if (!abort) begin
                  checks++;
                  if (expQ.size() == 0) begin
                     failures++;
                     $display("[TB] FAIL res_record actual=%h required=none", curRes);
                  end else begin
                     if (curRes !== expQ[0]) begin
                        failures++;
                        $display("[TB] FAIL res_record actual=%h required=%h", curRes, expQ[0]);
                     end
                     void'(expQ.pop_front());
                  end
                  if (!resExit) expDbl = ~expDbl;
               end
            end
         end else begin
            if (resHeld && !abort) begin
               checks++;
               failures++;
               $display("[TB] FAIL res_valid_drop actual=0 required=1");
            end
            resHeld = 1'b0;
         end
      end
   end

   // Reference scan: every row top to bottom, CORES-wide column steps while a window fits.
   task automatic pushScale(input int w, input int h, input int win, input int sc);
      rec_t r;
      if (win > w || win > h) return;
      for (int y = 0; y + win <= h; y++) begin
         for (int x = 0; x + win <= w; x += CORES) begin
            r.isExit = 1'b0;
            r.x = CW'(x);
            r.y = CW'(y);
            r.scale = SW'(sc);
            for (int l = 0; l < CORES; l++) r.mask[l] = (x + l + win <= w);
            expQ.push_back(r);
         end
      end
   endtask

   task automatic pushExit(input int w, input int h);
      rec_t r;
      r = '0;
      r.isExit = 1'b1;
      r.x = CW'(w);
      r.y = CW'(h);
      expQ.push_back(r);
   endtask

   task automatic startFrame(input int w, input int h, input int n);
      @(posedge clk); #2;
      cfgWidth = CW'(w);
      cfgHeight = CW'(h);
      cfgNumScales = SW'(n);
      expDbl = 1'b0;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk); #2;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_ready actual=%b required=1", ready);
      end
      checks++;
      if ({done, scaleReq, prepStart, winValid, resValid, resExit, winDblbuf, batchCnt, scaleIdx,
           winX, winY, winMask, resX, resY, resScale, resMask} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs actual=nonzero required=0 (batch=%h win=%b res=%b)",
                  batchCnt, winValid, resValid);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({ready, scaleReq, winValid} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL idle_hold actual=%b required=100", {ready, scaleReq, winValid});
      end
   endtask

   task automatic test_single_scale;
      bit seen;
      int p0, a0;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 4;
      pushScale(8, 6, 4, 0);
      pushExit(100, 80);
      p0 = prepStarts; a0 = winAccepts;
      startFrame(100, 80, 1);
      checks++;
      if ({ready, scaleReq} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL start_leaves_idle actual=%b required=01", {ready, scaleReq});
      end
      waitDone(400, seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL single_done actual=0 required=1");
      end
      checks++;
      if (batchCnt !== 16'd6 || winAccepts - a0 != 6 || prepStarts - p0 != 1) begin
         failures++;
         $display("[TB] FAIL single_counts actual=%0d/%0d/%0d required=6/6/1",
                  batchCnt, winAccepts - a0, prepStarts - p0);
      end
      @(posedge clk); #2;
      checks++;
      if ({done, ready} !== 2'b01 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL single_end actual=%b,q%0d required=01,q0", {done, ready}, expQ.size());
      end
   endtask

   task automatic test_skip_scale;
      bit seen;
      int p0, s0;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 10;
      tabW[1] = 6; tabH[1] = 5; tabWin[1] = 4;
      pushScale(8, 6, 10, 0);
      pushScale(6, 5, 4, 1);
      pushExit(64, 48);
      p0 = prepStarts; s0 = scaleAcks;
      startFrame(64, 48, 2);
      waitDone(400, seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL skip_done actual=0 required=1");
      end
      checks++;
      if (prepStarts - p0 != 1 || scaleAcks - s0 != 2) begin
         failures++;
         $display("[TB] FAIL skip_prep_scalereq actual=%0d/%0d required=1/2", prepStarts - p0, scaleAcks - s0);
      end
      checks++;
      if (batchCnt !== 16'd2 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL skip_batches actual=%0d,q%0d required=2,q0", batchCnt, expQ.size());
      end
   endtask

   task automatic test_stall;
      bit seen;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 4;
      pushScale(8, 6, 4, 0);
      pushExit(33, 22);
      winStallCnt = 5;
      resStallCnt = 5;
      startFrame(33, 22, 1);
      waitDone(500, seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL stall_done actual=0 required=1");
      end
      checks++;
      if (winDblbuf !== expDbl || expDbl !== 1'b0 || batchCnt !== 16'd6) begin
         failures++;
         $display("[TB] FAIL stall_dblbuf actual=%b,%0d required=0,6", winDblbuf, batchCnt);
      end
   endtask

   task automatic test_abort_wait;
      bit seen, hit;
      int a0;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 4;
      pushScale(8, 6, 4, 0);
      a0 = winAccepts;
      startFrame(7, 9, 1);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (winAccepts != a0) hit = 1'b1;
      end
      checks++;
      if (!hit || winValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_reach_wait actual=%b,%b required=1,0", hit, winValid);
      end
      expQ.delete();
      pushExit(7, 9);
      abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      checks++;
      if ({resValid, resExit} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL abort_to_exit actual=%b required=11", {resValid, resExit});
      end
      waitDone(50, seen);
      checks++;
      if (!seen || batchCnt !== 16'd1) begin
         failures++;
         $display("[TB] FAIL abort_done actual=%b,%0d required=1,1", seen, batchCnt);
      end
      repeat (6) @(posedge clk);
      #2;
      checks++;
      if ({ready, resValid, winValid} !== 3'b100 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL abort_late_proc actual=%b,q%0d required=100,q0", {ready, resValid, winValid}, expQ.size());
      end
   endtask

   task automatic test_abort_ready;
      bit seen, hit;
      int a0;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 4;
      pushScale(8, 6, 4, 0);
      a0 = winAccepts;
      winStallCnt = 100;
      startFrame(12, 13, 1);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (winValid) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("[TB] FAIL abort_ready_issue actual=0 required=1");
      end
      expQ.delete();
      pushExit(12, 13);
      abort = 1'b1;
      forceWinReady = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      forceWinReady = 1'b0;
      winStallCnt = 0;
      checks++;
      if (batchCnt !== 16'd0 || {resValid, resExit} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL abort_beats_ready actual=%0d,%b required=0,11", batchCnt, {resValid, resExit});
      end
      waitDone(50, seen);
      checks++;
      if (!seen || winAccepts != a0 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL abort_ready_done actual=%b,%0d,q%0d required=1,0,q0", seen, winAccepts - a0, expQ.size());
      end
   endtask

   task automatic test_reset_mid;
      bit seen, hit;
      tabW[0] = 8; tabH[0] = 6; tabWin[0] = 4;
      pushScale(8, 6, 4, 0);
      startFrame(5, 5, 1);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (winValid) hit = 1'b1;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (!hit || {ready, winValid, resValid, batchCnt} !== {3'b100, 16'd0}) begin
         failures++;
         $display("[TB] FAIL reset_async actual=%b,%b,%b,%0d required=1,0,0,0", hit, ready, winValid, batchCnt);
      end
      expQ.delete();
      @(posedge clk); #2;
      reset = 1'b0;
      pushScale(8, 6, 4, 0);
      pushExit(5, 5);
      startFrame(5, 5, 1);
      waitDone(400, seen);
      checks++;
      if (!seen || batchCnt !== 16'd6 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL reset_rescan actual=%b,%0d,q%0d required=1,6,q0", seen, batchCnt, expQ.size());
      end
   endtask

   task automatic test_zero_scales;
      bit seen;
      int p0, s0, a0;
      pushExit(17, 19);
      p0 = prepStarts; s0 = scaleAcks; a0 = winAccepts;
      startFrame(17, 19, 0);
      checks++;
      if ({resValid, resExit, scaleReq} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL zero_exit_direct actual=%b required=110", {resValid, resExit, scaleReq});
      end
      waitDone(50, seen);
      checks++;
      if (!seen || prepStarts != p0 || scaleAcks != s0 || winAccepts != a0 || batchCnt !== 16'd0) begin
         failures++;
         $display("[TB] FAIL zero_scales actual=%b,%0d,%0d,%0d,%0d required=1,0,0,0,0",
                  seen, prepStarts - p0, scaleAcks - s0, winAccepts - a0, batchCnt);
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL zero_queue actual=%0d required=0", expQ.size());
      end
   endtask

   // Scenario sequence; each task leaves the DUT idle for the next one.
   initial begin
      for (int i = 0; i < 4; i++) begin
         tabW[i] = '0; tabH[i] = '0; tabWin[i] = '0;
      end
      curWin = '0; curRes = '0; winSnap = '0; resSnap = '0;
      @(posedge clk); #2;
      test_reset;
      test_single_scale;
      test_skip_scale;
      test_stall;
      test_abort_wait;
      test_abort_ready;
      test_reset_mid;
      test_zero_scales;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/window_scan_sequencer.md
WINDOW_SCAN_SEQUENCER -- requirements
Module: window_scan_sequencer

Interface
REQ-001 Parameter CORES, default 4, SHALL set the number of SIMD lanes per batch (1..16).
REQ-002 Parameter CW, default 10, SHALL set the coordinate/size width.
REQ-003 Parameter SW, default 5, SHALL set the scale index width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 start  in  1  begins a frame when sampled in IDLE; ignored elsewhere.
REQ-007 abort  in  1  terminates the frame early.
REQ-008 cfg_width / cfg_height  in  CW each  base image size, echoed in the exit record.
REQ-009 cfg_num_scales  in  SW  number of scales to scan (0 = exit immediately).
REQ-010 ready  out  1  high only in IDLE.
REQ-011 done  out  1  one-cycle pulse when the frame completes.
REQ-012 scale_req  out  1  request parameters for scale scale_idx; scale_ack  in  1  accepts.
REQ-013 scale_idx  out  SW  current scale index.
REQ-014 scale_w / scale_h / scale_win  in  CW each  scaled image size and window size, valid with scale_ack.
REQ-015 prep_start  out  1  one-cycle pulse to start resize + integral image build; prep_done  in  1  build complete.
REQ-016 win_valid  out  1  / win_ready  in  1  batch issue handshake.
REQ-017 win_x / win_y  out  CW each  lane-0 window origin.
REQ-018 win_mask  out  CORES  per-lane valid mask; win_dblbuf  out  1  buffer select.
REQ-019 proc_done  in  1  one-cycle pulse: cluster finished the accepted batch.
REQ-020 res_valid  out  1  / res_ready  in  1  result record handshake.
REQ-021 res_x / res_y  out  CW each; res_scale  out  SW; res_mask  out  CORES; res_exit  out  1.
REQ-022 batch_cnt  out  16  batches accepted this frame, saturating at 0xFFFF.

Function
REQ-023 The FSM SHALL have states IDLE, SCALE_REQ, PREP, ISSUE, WAIT_PROC, STORE, ADVANCE, EXIT, DONE.
REQ-024 IDLE -> SCALE_REQ on start: clear x, y, scale_idx, batch_cnt and dblbuf; if cfg_num_scales=0, go directly to EXIT.
REQ-025 SCALE_REQ SHALL hold scale_req=1 until scale_ack and latch scale_w/h/win on the ack cycle.
REQ-026 Skip rule: if the latched win exceeds w or exceeds h, go to ADVANCE-scale without prep or batches; otherwise go to PREP.
REQ-027 PREP SHALL pulse prep_start on its first cycle only, then wait for prep_done, then enter ISSUE with x=0, y=0.
REQ-028 Lane mask: bit l = 1 iff x+l+win <= w (compute at CW+1 bits, no wrap).
REQ-029 ISSUE SHALL hold win_valid with stable outputs until win_ready; on acceptance go to WAIT_PROC and increment batch_cnt.
REQ-030 WAIT_PROC -> STORE on proc_done; proc_done outside WAIT_PROC SHALL be ignored.
REQ-031 STORE SHALL hold res_valid with res_exit=0, res_x=x, res_y=y, res_scale=scale_idx, res_mask=mask until res_ready, then toggle dblbuf and go to ADVANCE.
REQ-032 ADVANCE step: if x+CORES+win <= w, then x += CORES; else if y+1+win <= h, then x=0 and y += 1; else end of scale; return to ISSUE when not end of scale.
REQ-033 End of scale: scale_idx += 1; if scale_idx+1 = cfg_num_scales, go to EXIT, else go to SCALE_REQ.
REQ-034 EXIT SHALL hold res_valid with res_exit=1, res_x=cfg_width, res_y=cfg_height, res_scale=0, res_mask=0 until res_ready, then go to DONE.
REQ-035 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-036 abort=1 in any state other than IDLE, EXIT or DONE SHALL force EXIT next cycle.
REQ-037 On abort, any pending win_valid or res_valid SHALL drop without completing; this is the sole exception to the hold rule.
REQ-038 abort together with win_ready in the same cycle: abort SHALL win, and batch_cnt SHALL not increment.
REQ-039 scale_req, win_valid and res_valid SHALL each be registered outputs, at most one asserted at a time.

Reset
REQ-040 Asserting reset SHALL immediately force IDLE, x=y=0, scale_idx=0, dblbuf=0, batch_cnt=0.
REQ-041 While in reset, all outputs SHALL be 0 except ready=1.
REQ-042 Reset asserted mid-frame SHALL discard all progress, with no exit record emitted.

Verification
REQ-043 CORES=4, scale 8x6, win=4, 1 scale: batches (0,0,1111), (4,0,0001), (0,1,1111), (4,1,0001), (0,2,1111), (4,2,0001), then exit record (cfg_width, cfg_height); batch_cnt=6; done pulse.
REQ-044 2 scales, scale 0 win=10 with w=8: no prep_start for scale 0; scale_req issued for scale 1; normal scan proceeds.
REQ-045 res_ready and win_ready held low for 5 cycles: valid and all payloads stable; dblbuf toggles exactly once per stored record.
REQ-046 abort asserted in WAIT_PROC: next state EXIT, exit record emitted, done pulse; proc_done arriving afterwards is ignored.
REQ-047 reset pulsed during ISSUE: ready=1 and win_valid=0 immediately; a subsequent start rescans from (0,0), scale 0.
REQ-048 cfg_num_scales=0: start -> exit record -> done, with no scale_req, prep_start or batch issued.
